trig_conditioner: RTL and testbench

TRIG_CONDITIONER -- requirements
Module: trig_conditioner

---
 rtl/trig_pkg.sv | 34 +++
 rtl/trig_conditioner_if.sv | 16 +
 rtl/trig_channel.sv | 144 ++++++++++++++
 rtl/trig_conditioner.sv | 57 +++++
 tb/tb_trig_conditioner.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/trig_pkg.sv
// Shared types and elaboration-time helpers for the trigger conditioner.
package trig_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_FILT = 2'b01,
    MODE_DLY  = 2'b10,
    MODE_HOLD = 2'b11
  } trig_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_PULSE,
    ST_HOLDOFF
  } trig_state_e;

  function automatic int unsigned delay_cycles(input int unsigned us,
                                               input int unsigned clk_per_us,
                                               input int neg);
    int d;
    d = int'(us * clk_per_us) - neg;
    return (d < 0) ? 0 : unsigned'(d);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/trig_conditioner_if.sv
// Per-channel bundle between the conditioner top and one trig_channel.
interface trig_conditioner_if;
  logic                 trig_in;
  logic                 en;
  logic                 clr_cnt;
  trig_pkg::trig_mode_e mode;
  logic                 smoothed;
  logic                 pulse;
  logic                 busy;
  logic [7:0]           drop_cnt;

  modport master (output trig_in, en, clr_cnt, mode,
                  input  smoothed, pulse, busy, drop_cnt);
  modport slave  (input  trig_in, en, clr_cnt, mode,
                  output smoothed, pulse, busy, drop_cnt);
endinterface

// File: rtl/trig_channel.sv
// One trigger channel: 2-flop sync, glitch filter, delay/pulse/holdoff FSM, drop counter.
module trig_channel
  import trig_pkg::*;
#(
  parameter int unsigned GLITCH_TICKS = 4,
  parameter int unsigned PULSE_TICKS  = 25,
  parameter int unsigned DELAY_CYC    = 65,
  parameter int unsigned HOLD_CYC     = 500
) (
  input  logic              clk,
  input  logic              rst,
  trig_conditioner_if.slave bus
);

  localparam int unsigned CMAX = max3(DELAY_CYC, PULSE_TICKS, HOLD_CYC);
  localparam int unsigned CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
  localparam int unsigned GW   = $clog2(GLITCH_TICKS + 1);
  localparam logic [GW-1:0] G_MAX  = GW'(GLITCH_TICKS);
  localparam logic [CW-1:0] D_LAST = CW'((DELAY_CYC > 0) ? DELAY_CYC - 1 : 0);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_TICKS - 1);
  localparam logic [CW-1:0] H_LAST = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  logic [1:0]    sync_q, vld_q;
  logic [GW-1:0] filt_cnt_q, filt_cnt_d, low_cnt_q, low_cnt_d;
  logic          smoothed_q, smoothed_d, prev_q;
  logic          armed_q, armed_d;
  logic [7:0]    drop_q, drop_d;
  logic          rise, active, accept, drop;

  trig_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          pulse_q;

  always_comb begin
    rise   = smoothed_q & ~prev_q;
    active = bus.en && (bus.mode != MODE_OFF);
    accept = (state_q == ST_IDLE) && rise && armed_q && active;
    drop   = rise && (state_q != ST_IDLE);

    // G samples at the new level are counted, the level flips on the following edge
    smoothed_d = smoothed_q;
    filt_cnt_d = '0;
    if (filt_cnt_q == G_MAX) smoothed_d = ~smoothed_q;
    else if (sync_q[1] != smoothed_q) filt_cnt_d = filt_cnt_q + 1'b1;

    // Arming needs a genuinely observed low, not the post-reset cleared synchronizer
    low_cnt_d = low_cnt_q;
    if (!vld_q[1] || sync_q[1]) low_cnt_d = '0;
    else if (low_cnt_q != G_MAX) low_cnt_d = low_cnt_q + 1'b1;

    armed_d = armed_q;
    if (accept) armed_d = 1'b0;
    else if (!smoothed_q && (low_cnt_q == G_MAX)) armed_d = 1'b1;

    drop_d = drop_q;
    if (bus.clr_cnt) drop_d = '0;
    else if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      vld_q      <= '0;
      filt_cnt_q <= '0;
      low_cnt_q  <= '0;
      smoothed_q <= 1'b0;
      prev_q     <= 1'b0;
      armed_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      sync_q     <= {sync_q[0], bus.trig_in};
      vld_q      <= {vld_q[0], 1'b1};
      filt_cnt_q <= filt_cnt_d;
      low_cnt_q  <= low_cnt_d;
      smoothed_q <= smoothed_d;
      prev_q     <= smoothed_q;
      armed_q    <= armed_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (!active) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            if (((bus.mode == MODE_DLY) || (bus.mode == MODE_HOLD)) && (DELAY_CYC > 0)) begin
              state_q <= ST_DELAY;
            end else begin
              state_q <= ST_PULSE;
              pulse_q <= 1'b1;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q == D_LAST) begin
            state_q <= ST_PULSE;
            pulse_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == P_LAST) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= ((bus.mode == MODE_HOLD) && (HOLD_CYC > 0)) ? ST_HOLDOFF : ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (cnt_q == H_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.smoothed = smoothed_q;
  assign bus.pulse    = pulse_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.drop_cnt = drop_q;

endmodule

// File: rtl/trig_conditioner.sv
// Multi-channel trigger conditioner: N_CH independent trig_channel instances.
module trig_conditioner
  import trig_pkg::*;
#(
  parameter int unsigned N_CH                   = 2,
  parameter int unsigned CLK_PER_US             = 50,
  parameter int unsigned TRIG_DELAY_IN_US       = 2,
  parameter int          TRIG_DELAY_IN_20NS_NEG = 35,
  parameter int unsigned GLITCH_TICKS           = 4,
  parameter int unsigned PULSE_TICKS            = 25,
  parameter int unsigned HOLDOFF_US             = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   trig_in,
  input  logic [1:0]        mode,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              clr_cnt,
  output logic [N_CH-1:0]   smoothed_trig,
  output logic [N_CH-1:0]   trig_pulse,
  output logic [N_CH-1:0]   busy,
  output logic [8*N_CH-1:0] drop_cnt,
  output logic              any_pulse
);

  localparam int unsigned DELAY_CYC =
    delay_cycles(TRIG_DELAY_IN_US, CLK_PER_US, TRIG_DELAY_IN_20NS_NEG);
  localparam int unsigned HOLD_CYC = HOLDOFF_US * CLK_PER_US;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    trig_conditioner_if bus ();

    assign bus.trig_in = trig_in[k];
    assign bus.en      = ch_en[k];
    assign bus.clr_cnt = clr_cnt;
    assign bus.mode    = trig_mode_e'(mode);

    trig_channel #(
      .GLITCH_TICKS (GLITCH_TICKS),
      .PULSE_TICKS  (PULSE_TICKS),
      .DELAY_CYC    (DELAY_CYC),
      .HOLD_CYC     (HOLD_CYC)
    ) u_ch (
      .clk (clk),
      .rst (reset),
      .bus (bus.slave)
    );

    assign smoothed_trig[k]   = bus.smoothed;
    assign trig_pulse[k]      = bus.pulse;
    assign busy[k]            = bus.busy;
    assign drop_cnt[8*k +: 8] = bus.drop_cnt;
  end

  assign any_pulse = |trig_pulse;

endmodule

// File: tb/tb_trig_conditioner.sv
// Directed bench for trig_conditioner at default parameters (D=65, pulse 25, holdoff 500).
module tb_trig_conditioner;

  localparam int unsigned N_CH = 2;
  localparam int          RUN  = 650;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_CH-1:0]   trig_in, ch_en, smoothed_trig, trig_pulse, busy;
  logic [1:0]        mode;
  logic              clr_cnt;
  logic [8*N_CH-1:0] drop_cnt;
  logic              any_pulse;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #10 clk = ~clk;

  trig_conditioner #(.N_CH(N_CH)) dut (
    .clk           (clk),
    .reset         (reset),
    .trig_in       (trig_in),
    .mode          (mode),
    .ch_en         (ch_en),
    .clr_cnt       (clr_cnt),
    .smoothed_trig (smoothed_trig),
    .trig_pulse    (trig_pulse),
    .busy          (busy),
    .drop_cnt      (drop_cnt),
    .any_pulse     (any_pulse)
  );

  typedef struct {
    logic [1:0] mode;
    logic       en;
    int         high_len;
    int         exp_smooth;
    int         exp_pulse;
    int         exp_width;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    trig_in = '0;
    clr_cnt = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();
  endtask

  // Sample index k = state after the k-th rising edge with trig_in[0] presented.
  task automatic run_vec(input int idx, input vec_t v);
    int s_first = -1;
    int p_first = -1;
    int a_first = -1;
    int width   = 0;
    int ch1_act = 0;
    mode       = v.mode;
    ch_en      = {1'b1, v.en};
    trig_in    = '0;
    trig_in[0] = (v.high_len > 0);
    for (int k = 0; k < RUN; k++) begin
      step();
      if (smoothed_trig[0] && s_first < 0) s_first = k;
      if (trig_pulse[0]) begin
        if (p_first < 0) p_first = k;
        width++;
      end
      if (any_pulse && a_first < 0) a_first = k;
      if (smoothed_trig[1] || trig_pulse[1] || busy[1] || (drop_cnt[15:8] != 8'd0)) ch1_act++;
      trig_in[0] = (k + 1 < v.high_len);
    end
    check($sformatf("v%0d smooth_rise", idx), s_first, v.exp_smooth);
    check($sformatf("v%0d pulse_rise", idx), p_first, v.exp_pulse);
    check($sformatf("v%0d pulse_width", idx), width, v.exp_width);
    check($sformatf("v%0d any_pulse_rise", idx), a_first, v.exp_pulse);
    check($sformatf("v%0d drop_cnt0", idx), int'(drop_cnt[7:0]), 0);
    check($sformatf("v%0d ch1_quiet", idx), ch1_act, 0);
  endtask

  function automatic bit a_high(input int e);
    return (e < 50) || (e >= 300 && e < 350) || (e >= 700 && e < 750);
  endfunction

  initial begin
    int n_rise, p1, p2, b596, b597, prev_p, s_seen, p_seen, ch0_act, nz, e, first;

    vecs[0] = '{2'b10, 1'b1, 200,  6, 72, 25};
    vecs[1] = '{2'b01, 1'b1, 200,  6,  7, 25};
    vecs[2] = '{2'b10, 1'b1,   3, -1, -1,  0};
    vecs[3] = '{2'b01, 1'b1,   4,  6,  7, 25};
    vecs[4] = '{2'b00, 1'b1, 200,  6, -1,  0};
    vecs[5] = '{2'b10, 1'b0, 200,  6, -1,  0};
    vecs[6] = '{2'b11, 1'b1, 200,  6, 72, 25};

    reset   = 1'b1;
    trig_in = '0;
    mode    = 2'b10;
    ch_en   = '1;
    clr_cnt = 1'b0;
    #1;
    check("reset_outputs", int'({smoothed_trig, trig_pulse, busy, drop_cnt, any_pulse}), 0);
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Mode 11: second trigger lands in holdoff and is dropped, third is accepted.
    mode  = 2'b11;
    ch_en = '1;
    do_reset();
    n_rise = 0; p1 = -1; p2 = -1; b596 = -1; b597 = -1; prev_p = 0;
    trig_in[0] = a_high(0);
    for (int k = 0; k < 900; k++) begin
      step();
      if (trig_pulse[0] && !prev_p) begin
        n_rise++;
        if (n_rise == 1) p1 = k;
        if (n_rise == 2) p2 = k;
      end
      prev_p = int'(trig_pulse[0]);
      if (k == 596) b596 = int'(busy[0]);
      if (k == 597) b597 = int'(busy[0]);
      trig_in[0] = a_high(k + 1);
    end
    check("hold first_pulse", p1, 72);
    check("hold pulse_count", n_rise, 2);
    check("hold second_pulse", p2, 772);
    check("hold busy_last", b596, 1);
    check("hold busy_done", b597, 0);
    check("hold drop_cnt", int'(drop_cnt[7:0]), 1);

    // Reset during DELAY, input kept high across release.
    mode = 2'b10;
    do_reset();
    trig_in[0] = 1'b1;
    repeat (30) step();
    check("rst busy_in_delay", int'(busy[0]), 1);
    #5 reset = 1'b1;
    #1;
    check("rst async_clear", int'({smoothed_trig, trig_pulse, busy, drop_cnt, any_pulse}), 0);
    step();
    reset = 1'b0;
    s_seen = 0; p_seen = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (smoothed_trig[0]) s_seen = 1;
      if (trig_pulse[0] || busy[0]) p_seen = 1;
    end
    check("rst no_pulse_while_held", p_seen, 0);
    check("rst still_filtering", s_seen, 1);
    trig_in[0] = 1'b0;
    repeat (30) step();
    trig_in[0] = 1'b1;
    first = -1;
    for (int k = 0; k < 120; k++) begin
      step();
      if (trig_pulse[0] && first < 0) first = k;
    end
    check("rst rearmed_pulse", first, 72);

    // Force off mid-pulse.
    mode = 2'b01;
    do_reset();
    trig_in[0] = 1'b1;
    repeat (11) step();
    check("off pulse_before", int'(trig_pulse[0]), 1);
    mode = 2'b00;
    step();
    check("off pulse_after", int'(trig_pulse[0]), 0);
    check("off busy_after", int'(busy[0]), 0);
    check("off smoothed_kept", int'(smoothed_trig[0]), 1);

    // Channel 1 drop saturation and clear; channel 0 idle throughout.
    mode = 2'b11;
    do_reset();
    ch0_act = 0;
    e = 0;
    for (int k = 0; k < 6000; k++) begin
      trig_in[1] = ((e % 16) < 8);
      e++;
      step();
      if (smoothed_trig[0] || trig_pulse[0] || busy[0]) ch0_act++;
    end
    check("sat drop_cnt1", int'(drop_cnt[15:8]), 255);
    check("sat drop_cnt0", int'(drop_cnt[7:0]), 0);
    check("sat ch0_quiet", ch0_act, 0);
    clr_cnt = 1'b1;
    nz = 0;
    for (int k = 0; k < 40; k++) begin
      trig_in[1] = ((e % 16) < 8);
      e++;
      step();
      if (drop_cnt[15:8] != 8'd0) nz++;
    end
    check("clr held_zero", nz, 0);
    clr_cnt = 1'b0;
    for (int k = 0; k < 200; k++) begin
      trig_in[1] = ((e % 16) < 8);
      e++;
      step();
    end
    check("clr recount", int'(drop_cnt[15:8] != 8'd0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
